// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC engine: state encoding and window geometry.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

  localparam int WIN_SIZE   = 4;
  localparam int WIN_ELEMS  = WIN_SIZE * WIN_SIZE;
  localparam int IDX_W      = $clog2(WIN_ELEMS);
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/mac_datapath.sv
// Multiplier, clearable accumulator and saturating output stage for the 4x4 MAC.
module mac_datapath
  import conv_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = 20,
  parameter int OUT_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              load,
  input  logic [DATA_W-1:0] pic_data,
  input  logic [DATA_W-1:0] filt_data,
  output logic [ACC_W-1:0]  acc_out,
  output logic [DATA_W-1:0] sat_out
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [ACC_W-1:0]    acc_final;
  logic [ACC_W-1:0]    shifted;
  logic [DATA_W-1:0]   sat_final;

  assign prod      = {{DATA_W{1'b0}}, pic_data} * {{DATA_W{1'b0}}, filt_data};
  assign acc_next  = acc + ACC_W'(prod);
  // The last product arrives in the same cycle the result is captured,
  // so the output stage sees the sum including it.
  assign acc_final = en ? acc_next : acc;
  assign shifted   = acc_final >> OUT_SHIFT;

  // Clamp anything that does not fit in DATA_W bits after the shift.
  always_comb begin
    sat_final = shifted[DATA_W-1:0];
    if (|shifted[ACC_W-1:DATA_W]) sat_final = '1;
  end

  // Accumulator and held result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      acc_out <= '0;
      sat_out <= '0;
    end else begin
      if (clr)     acc <= '0;
      else if (en) acc <= acc_next;
      if (load) begin
        acc_out <= acc_final;
        sat_out <= sat_final;
      end
    end
  end

endmodule

// File: rtl/conv_mac_unit.sv
// Sequential 4x4 multiply-accumulate engine fed by the picture/filter buffers.
//
//   state | meaning
//   IDLE  | waiting for mac_start
//   RUN   | issuing 16 row-major buffer reads
//   DRAIN | last read data returns and is accumulated
//   DONE  | one-cycle mac_done, results valid
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = 20,
  parameter int OUT_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mac_start,
  input  logic [DATA_W-1:0] pic_data,
  input  logic [DATA_W-1:0] filt_data,
  output logic              rd_en,
  output logic [1:0]        rd_i,
  output logic [1:0]        rd_j,
  output logic              busy,
  output logic              mac_done,
  output logic [ACC_W-1:0]  acc_out,
  output logic [DATA_W-1:0] sat_out
);

  mac_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic             clr;
  logic             load;

  assign rd_i = idx[3:2];
  assign rd_j = idx[1:0];
  assign clr  = (state == IDLE) && mac_start;
  assign load = (state == DRAIN);

  // Sequencer: state, window index, read-data valid pipe and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      valid    <= 1'b0;
      rd_en    <= 1'b0;
      busy     <= 1'b0;
      mac_done <= 1'b0;
    end else begin
      valid    <= rd_en;
      mac_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mac_start) begin
            state <= RUN;
            idx   <= '0;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          idx <= idx + 1'b1;
          if (idx == IDX_W'(WIN_ELEMS - 1)) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end
        end
        DRAIN: begin
          state    <= DONE;
          busy     <= 1'b0;
          mac_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  mac_datapath #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (valid),
    .load     (load),
    .pic_data (pic_data),
    .filt_data(filt_data),
    .acc_out  (acc_out),
    .sat_out  (sat_out)
  );

endmodule

// File: tb/tb_conv_mac_unit.sv
// Self-checking bench for conv_mac_unit: vector table, random windows, and
// hand-written sequences for back-to-back runs and reset mid-run.
module tb_conv_mac_unit;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int NVEC   = 12;

  typedef struct {
    logic [15:0][DATA_W-1:0] pic;
    logic [15:0][DATA_W-1:0] filt;
    int                      exp_acc;
    int                      exp_sat;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mac_start = 1'b0;
  logic [DATA_W-1:0] pic_data = '0;
  logic [DATA_W-1:0] filt_data = '0;
  logic              rd_en;
  logic [1:0]        rd_i;
  logic [1:0]        rd_j;
  logic              busy;
  logic              mac_done;
  logic [ACC_W-1:0]  acc_out;
  logic [DATA_W-1:0] sat_out;

  logic [15:0][DATA_W-1:0] pic_mem;
  logic [15:0][DATA_W-1:0] filt_mem;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NVEC];

  conv_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_SHIFT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .mac_start(mac_start),
    .pic_data (pic_data),
    .filt_data(filt_data),
    .rd_en    (rd_en),
    .rd_i     (rd_i),
    .rd_j     (rd_j),
    .busy     (busy),
    .mac_done (mac_done),
    .acc_out  (acc_out),
    .sat_out  (sat_out)
  );

  always #5 clk = ~clk;

  // Buffer model: read data for the address strobed in one cycle appears in
  // the next; unrelated garbage is driven whenever no read was issued.
  initial begin
    logic       en_q;
    logic [3:0] addr_q;
    forever begin
      @(negedge clk);
      en_q   = rd_en;
      addr_q = {rd_i, rd_j};
      @(posedge clk);
      #1;
      if (en_q) begin
        pic_data  = pic_mem[addr_q];
        filt_data = filt_mem[addr_q];
      end else begin
        pic_data  = DATA_W'($urandom);
        filt_data = DATA_W'($urandom);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_sum(input vec_t v);
    int s = 0;
    for (int k = 0; k < 16; k++) s += int'(v.pic[k]) * int'(v.filt[k]);
    return s;
  endfunction

  function automatic int model_sat(input int s);
    int sh = s >> 4;
    return (sh > 255) ? 255 : sh;
  endfunction

  // Pulse start, follow one run, and check timing, index order and results.
  task automatic run_vector(input vec_t v, input string tag);
    int cyc, done_cyc, busy_n, rd_n;
    logic seq_ok;
    pic_mem  = v.pic;
    filt_mem = v.filt;
    @(negedge clk);
    mac_start = 1'b1;
    @(negedge clk);
    mac_start = 1'b0;
    cyc = 1; done_cyc = 0; busy_n = 0; rd_n = 0; seq_ok = 1'b1;
    while (cyc <= 40 && done_cyc == 0) begin
      if (busy) busy_n++;
      if (rd_en) begin
        if ({rd_i, rd_j} != 4'(rd_n)) seq_ok = 1'b0;
        rd_n++;
      end
      if (mac_done) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " done_latency"}, done_cyc, 18);
    check({tag, " busy_cycles"}, busy_n, 17);
    check({tag, " rd_en_cycles"}, rd_n, 16);
    check({tag, " index_order"}, {31'd0, seq_ok}, 1);
    check({tag, " acc_out"}, acc_out, v.exp_acc);
    check({tag, " sat_out"}, sat_out, v.exp_sat);
    @(negedge clk);
    check({tag, " done_single_pulse"}, {31'd0, mac_done}, 0);
    check({tag, " acc_out_held"}, acc_out, v.exp_acc);
  endtask

  initial begin
    int dones, cyc, bad;
    int done_at [3];
    vec_t v;

    // Directed table: hand-computed sums around the saturation boundary.
    for (int n = 0; n < NVEC; n++) begin
      vecs[n].pic = '0; vecs[n].filt = '0;
      vecs[n].exp_acc = 0; vecs[n].exp_sat = 0;
    end
    for (int k = 0; k < 16; k++) begin
      vecs[0].pic[k] = 8'd1;   vecs[0].filt[k] = 8'd1;
      vecs[1].pic[k] = 8'd255; vecs[1].filt[k] = 8'd255;
      vecs[2].pic[k] = 8'(k);  vecs[2].filt[k] = 8'd1;
      vecs[3].pic[k] = 8'd16;  vecs[3].filt[k] = 8'd1;
    end
    vecs[0].exp_acc = 16;      vecs[0].exp_sat = 1;
    vecs[1].exp_acc = 1040400; vecs[1].exp_sat = 255;
    vecs[2].exp_acc = 120;     vecs[2].exp_sat = 7;
    vecs[3].exp_acc = 256;     vecs[3].exp_sat = 16;
    vecs[4].pic[0] = 8'd255; vecs[4].filt[0] = 8'd16;
    vecs[4].exp_acc = 4080;    vecs[4].exp_sat = 255;
    vecs[5].pic[0] = 8'd255; vecs[5].filt[0] = 8'd16;
    vecs[5].pic[9] = 8'd1;   vecs[5].filt[9] = 8'd16;
    vecs[5].exp_acc = 4096;    vecs[5].exp_sat = 255;
    vecs[6].pic[3] = 8'd255; vecs[6].filt[3] = 8'd15;
    vecs[6].pic[14] = 8'd254; vecs[6].filt[14] = 8'd1;
    vecs[6].exp_acc = 4079;    vecs[6].exp_sat = 254;
    vecs[7].exp_acc = 0;       vecs[7].exp_sat = 0;
    // Random windows, expectations from the reference model.
    for (int n = 8; n < NVEC; n++) begin
      for (int k = 0; k < 16; k++) begin
        vecs[n].pic[k]  = 8'($urandom_range(0, 255));
        vecs[n].filt[k] = 8'($urandom_range(0, (n == 8) ? 15 : 255));
      end
      vecs[n].exp_acc = model_sum(vecs[n]);
      vecs[n].exp_sat = model_sat(vecs[n].exp_acc);
    end

    // Reset state.
    pic_mem = '0; filt_mem = '0;
    @(negedge clk);
    check("reset rd_en", {31'd0, rd_en}, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset mac_done", {31'd0, mac_done}, 0);
    check("reset rd_ij", {28'd0, rd_i, rd_j}, 0);
    check("reset acc_out", acc_out, 0);
    check("reset sat_out", sat_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int n = 0; n < NVEC; n++) run_vector(vecs[n], $sformatf("vec%0d", n));

    // mac_start held high: runs repeat every 19 cycles with no carried-over sum.
    v = vecs[9];
    pic_mem = v.pic; filt_mem = v.filt;
    @(negedge clk);
    mac_start = 1'b1;
    dones = 0; cyc = 0;
    while (dones < 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (mac_done) begin
        done_at[dones] = cyc;
        dones++;
        check($sformatf("held run%0d acc_out", dones), acc_out, v.exp_acc);
        if (dones == 3) mac_start = 1'b0;
      end
    end
    check("held done_count", dones, 3);
    check("held first_latency", done_at[0], 18);
    check("held period1", done_at[1] - done_at[0], 19);
    check("held period2", done_at[2] - done_at[1], 19);
    @(negedge clk);
    @(negedge clk);
    check("held stops_after_release", {31'd0, busy}, 0);

    // Reset asserted in the 8th RUN cycle.
    v = vecs[10];
    pic_mem = v.pic; filt_mem = v.filt;
    @(negedge clk);
    mac_start = 1'b1;
    @(negedge clk);
    mac_start = 1'b0;
    for (int c = 1; c < 8; c++) @(negedge clk);
    check("midrst pre rd_en", {31'd0, rd_en}, 1);
    rst = 1'b0;
    #1;
    check("midrst rd_en", {31'd0, rd_en}, 0);
    check("midrst busy", {31'd0, busy}, 0);
    check("midrst rd_ij", {28'd0, rd_i, rd_j}, 0);
    check("midrst acc_out", acc_out, 0);
    check("midrst sat_out", sat_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (mac_done || busy) bad++;
    end
    check("midrst no_activity", bad, 0);
    run_vector(vecs[11], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
